scan_demux_n: RTL and testbench

- Parametrised, registered 1-to-N demultiplexer, successor to the fixed 1-to-16 gate-level demux.
- Two modes:
  - Manual: routes the enable to the channel chosen by the select input.
  - Scan: an internal prescaled counter steps the active channel round-robin.
- Drives multiplexed LED matrix rows and display digit enables, where channel ordering matches the existing demux (channel k drives out[CHANNELS-1-k]).

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_prescaler.sv | 30 +++
 rtl/scan_demux_n.sv | 127 ++++++++++++
 tb/tb_scan_demux_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the scan demux and other display drivers: mode encodings,
// FSM state type and the reversed one-hot decode helper.
package demux_pkg;

   localparam logic MODE_MANUAL  = 1'b0;
   localparam logic MODE_SCAN    = 1'b1;
   localparam int   MAX_CHANNELS = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // Channel idx of an n-channel bank drives bit n-1-idx; out-of-range idx yields zero.
   function automatic logic [MAX_CHANNELS-1:0] onehot_rev(input int unsigned idx,
                                                          input int unsigned n);
      logic [MAX_CHANNELS-1:0] v;
      v = '0;
      for (int k = 0; k < MAX_CHANNELS; k++) begin
         v[k] = (idx < n) && ((n - 1 - idx) == int'(k));
      end
      return v;
   endfunction

endpackage

// File: rtl/demux_prescaler.sv
// Modulo-DIV cycle counter with synchronous clear and count enable; o_tc is high
// while the count sits at DIV-1.
module demux_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(DIV - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == TC_VAL) ? '0 : r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/scan_demux_n.sv
// Registered 1-to-CHANNELS demux with manual select and prescaled round-robin scan.
// Define DEMUX_BLANK_EN to blank all outputs for one cycle on every channel change.
module scan_demux_n
   import demux_pkg::*;
#(
   parameter  int CHANNELS = 16,
   parameter  int SCAN_DIV = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                input_e,
   input  logic [SEL_W-1:0]    input_sel,
   input  logic                mode,
   output logic [CHANNELS-1:0] out,
   output logic [SEL_W-1:0]    cur_sel,
   output logic                step
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

`ifdef DEMUX_BLANK_EN
   if (SCAN_DIV < 2) begin : g_div_check
      $error("scan_demux_n: SCAN_DIV must be >= 2 when blanking is enabled");
   end
`endif

   state_t              r_state;
   state_t              w_next;
   logic [SEL_W-1:0]    r_cur_sel;
   logic [SEL_W-1:0]    w_cur_next;
   logic [CHANNELS-1:0] r_out;
   logic [CHANNELS-1:0] w_out_next;
   logic [CHANNELS-1:0] w_dec;
   logic                r_step;
   logic                w_step_next;
   logic                w_drive;
   logic                w_sel_ok;
   logic                w_clr;
   logic                w_en;
   logic                w_tc;

   demux_prescaler #(
      .DIV (SCAN_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_en),
      .o_tc  (w_tc)
   );

   assign w_sel_ok = (32'(input_sel) < 32'(CHANNELS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = IDLE;
      w_cur_next  = r_cur_sel;
      w_step_next = 1'b0;
      w_drive     = 1'b0;
      w_clr       = 1'b0;
      w_en        = 1'b0;
      if (input_e) begin
         w_next = (mode == MODE_SCAN) ? SCAN : MANUAL;
      end
      case (w_next)
         MANUAL: begin
            w_clr = 1'b1;
            if (w_sel_ok) begin
               w_cur_next = input_sel;
               w_drive    = 1'b1;
            end
         end
         SCAN: begin
            w_drive = 1'b1;
            // Only a hand-over from MANUAL restarts at channel 0; leaving IDLE resumes
            // the interrupted scan with its channel and prescaler count intact.
            if (r_state == MANUAL) begin
               w_cur_next = '0;
               w_clr      = 1'b1;
            end else begin
               w_en = 1'b1;
               if (w_tc) begin
                  w_cur_next  = (r_cur_sel == LAST_SEL) ? '0 : r_cur_sel + 1'b1;
                  w_step_next = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign w_dec = CHANNELS'(onehot_rev(32'(w_cur_next), 32'(CHANNELS)));

`ifdef DEMUX_BLANK_EN
   logic w_change;
   assign w_change   = (w_cur_next != r_cur_sel);
   assign w_out_next = (w_drive && !w_change) ? w_dec : '0;
`else
   assign w_out_next = w_drive ? w_dec : '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_sel <= '0;
         r_out     <= '0;
         r_step    <= 1'b0;
      end else begin
         r_cur_sel <= w_cur_next;
         r_out     <= w_out_next;
         r_step    <= w_step_next;
      end
   end

   assign out     = r_out;
   assign cur_sel = r_cur_sel;
   assign step    = r_step;

endmodule

// File: tb/tb_scan_demux_n.sv
// Bench for scan_demux_n: a 16-channel and a 10-channel instance share stimulus and
// are compared every cycle against a behavioural model plus hand-computed literals.
module tb_scan_demux_n;

   localparam int DIV = 4;
`ifdef DEMUX_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   localparam int LAT = BLANK ? 2 : 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_e;
   logic       in_mode;
   logic [3:0] in_sel;
   logic [15:0] out16;
   logic [3:0]  cur16;
   logic        step16;
   logic [9:0]  out10;
   logic [3:0]  cur10;
   logic        step10;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   scan_demux_n #(.CHANNELS(16), .SCAN_DIV(DIV)) u_dut16 (
      .clk(clk), .rst(rst), .input_e(in_e), .input_sel(in_sel), .mode(in_mode),
      .out(out16), .cur_sel(cur16), .step(step16)
   );

   scan_demux_n #(.CHANNELS(10), .SCAN_DIV(DIV)) u_dut10 (
      .clk(clk), .rst(rst), .input_e(in_e), .input_sel(in_sel), .mode(in_mode),
      .out(out10), .cur_sel(cur10), .step(step10)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Model: channel index, cycles spent on it, last mode (0 idle, 1 manual, 2 scan).
   int          m_ch[2];
   int          m_cnt[2];
   int          m_prev[2];
   logic [63:0] m_out[2];
   logic        m_step[2];

   always @(posedge clk or posedge rst) begin : model
      for (int i = 0; i < 2; i++) begin
         int          n;
         int          ch;
         int          cnt;
         int          prv;
         logic [63:0] o;
         logic        st;
         bit          chg;
         n   = (i == 0) ? 16 : 10;
         ch  = m_ch[i];
         cnt = m_cnt[i];
         prv = m_prev[i];
         o   = 64'h0;
         st  = 1'b0;
         chg = 1'b0;
         if (rst) begin
            ch = 0; cnt = 0; prv = 0;
         end else if (!in_e) begin
            prv = 0;
         end else if (!in_mode) begin
            prv = 1;
            cnt = 0;
            if (int'(in_sel) < n) begin
               chg = (int'(in_sel) != ch);
               ch  = int'(in_sel);
               o   = (BLANK && chg) ? 64'h0 : (64'd1 << (n - 1 - ch));
            end
         end else begin
            if (prv == 1) begin
               chg = (ch != 0);
               ch  = 0;
               cnt = 0;
            end else if (cnt == DIV - 1) begin
               ch  = (ch + 1) % n;
               cnt = 0;
               st  = 1'b1;
               chg = 1'b1;
            end else begin
               cnt = cnt + 1;
            end
            prv = 2;
            o   = (BLANK && chg) ? 64'h0 : (64'd1 << (n - 1 - ch));
         end
         m_ch[i]   <= ch;
         m_cnt[i]  <= cnt;
         m_prev[i] <= prv;
         m_out[i]  <= o;
         m_step[i] <= st;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out16",  64'(out16),  m_out[0]);
         check("cur16",  64'(cur16),  64'(m_ch[0]));
         check("step16", 64'(step16), 64'(m_step[0]));
         check("out10",  64'(out10),  m_out[1]);
         check("cur10",  64'(cur10),  64'(m_ch[1]));
         check("step10", 64'(step10), 64'(m_step[1]));
      end
   end

   task automatic wait_ch(input int c);
      int k;
      for (k = 0; k < 200; k++) begin
         if (int'(cur16) == c) break;
         @(negedge clk);
      end
      if (k == 200) begin
         n_chk++;
         $display("FAIL wait_ch: cur_sel never reached %0d (stuck at %0d)", c, cur16);
      end
   endtask

   initial begin
      int hi0;
      int steps;
      rst = 1'b1; in_e = 1'b0; in_mode = 1'b0; in_sel = 4'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_out",  64'(out16),  64'h0);
      check("rst_cur",  64'(cur16),  64'h0);
      check("rst_step", 64'(step16), 64'h0);

      // Manual selection, both banks
      rst = 1'b0; in_e = 1'b1; in_mode = 1'b0; in_sel = 4'd0;
      repeat (LAT) @(negedge clk);
      check("man_sel0", 64'(out16), 64'h8000);
      in_sel = 4'd15;
      repeat (LAT) @(negedge clk);
      check("man_sel15", 64'(out16), 64'h0001);
      in_sel = 4'd9;
      repeat (LAT) @(negedge clk);
      check("man10_sel9_out", 64'(out10), 64'h001);
      check("man10_sel9_cur", 64'(cur10), 64'd9);
      in_sel = 4'd12;
      repeat (LAT) @(negedge clk);
      check("man10_oor_out", 64'(out10), 64'h0);
      check("man10_oor_cur", 64'(cur10), 64'd9);
      check("man16_sel12",   64'(out16), 64'h0008);

      // Scan: one full 16-channel period
      in_mode = 1'b1;
      hi0 = 0; steps = 0;
      for (int k = 0; k <= 64; k++) begin
         @(negedge clk);
         if (k < 64 && out16 == 16'h8000) hi0++;
         if (k > 0 && step16) steps++;
      end
      check("scan_ch0_len",  64'(hi0),   BLANK ? 64'd3 : 64'd4);
      check("scan_steps",    64'(steps), 64'd16);
      check("scan_wrap16",   64'(cur16), 64'd0);
      check("scan_wrap10",   64'(cur10), 64'd6);

      // Enable drop mid-channel at channel 7
      wait_ch(7);
      @(negedge clk);
      in_e = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("drop_out", 64'(out16), 64'h0);
         check("drop_cur", 64'(cur16), 64'd7);
      end
      in_e = 1'b1;
      @(negedge clk);
      check("resume_cur", 64'(cur16), 64'd7);
      check("resume_out", 64'(out16), 64'h0100);
      repeat (2) @(negedge clk);
      check("resume_adv", 64'(cur16), 64'd8);

      // Asynchronous reset mid-scan at channel 5
      wait_ch(5);
      #2 rst = 1'b1;
      #1;
      check("arst_out16", 64'(out16),  64'h0);
      check("arst_cur16", 64'(cur16),  64'h0);
      check("arst_step",  64'(step16), 64'h0);
      check("arst_out10", 64'(out10),  64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cur", 64'(cur16), 64'd0);
      check("post_rst_out", 64'(out16), 64'h8000);
      repeat (6) @(negedge clk);

      // Scan back to manual
      in_mode = 1'b0; in_sel = 4'd3;
      repeat (LAT) @(negedge clk);
      check("scan2man", 64'(out16), 64'h1000);
      repeat (2) @(negedge clk);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
